// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-to-1 valid/ready stream mux with a registered output
// and a grant that stays locked on one channel for BURST beats.
// Ports: clk, rst (async, active high); in_data/in_valid/in_ready per
// channel; sel (MODE 0 select); out_data/out_valid/out_ready/out_src; busy.
module stream_mux_nto1 #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int MODE  = 0,
   parameter int BURST = 1,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_src,
   output logic               busy
);

   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic {ARB, XFER} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] rr_q, rr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] src_q, src_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] ch_data [N];
   logic             pick_ok;
   logic [SEL_W-1:0] pick;
   logic [SEL_W-1:0] rr_j;
   logic             rdy;
   logic             take;

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Candidate grant for the ARB state. Out-of-range sel never grants.
   always_comb begin
      pick_ok = 1'b0;
      pick    = '0;
      rr_j    = '0;
      if (MODE == 0) begin
         pick = sel;
         if (int'(sel) < N) begin
            pick_ok = in_valid[sel];
         end
      end else begin
         // Search rr+1, rr+2, ... modulo N; first hit wins.
         for (int k = 1; k <= N; k++) begin
            rr_j = SEL_W'((int'(rr_q) + k) % N);
            if (!pick_ok && in_valid[rr_j]) begin
               pick_ok = 1'b1;
               pick    = rr_j;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      src_d    = src_q;
      valid_d  = valid_q;
      in_ready = '0;
      take     = 1'b0;
      // Output slot is free if empty or draining this cycle.
      rdy      = !valid_q || out_ready;
      unique case (state_q)
         ARB: begin
            if (pick_ok) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            in_ready[grant_q] = rdy;
            take = in_valid[grant_q] && rdy;
            if (take) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(BURST - 1)) begin
                  state_d = ARB;
                  rr_d    = grant_q;
               end
            end
         end
         default: ;
      endcase
      if (take) begin
         data_d  = ch_data[grant_q];
         src_d   = grant_q;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB;
         grant_q <= '0;
         rr_q    <= SEL_W'(N - 1);
         cnt_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         src_q   <= src_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_src   = src_q;
   assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: scoreboard bench for stream_mux_nto1.
// Four instances cover external select, round-robin, burst lock and N=3.
module tb_stream_mux_nto1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sbq [4][$];

   logic [63:0] a_d, b_d, c_d;
   logic [47:0] d_d;
   logic [3:0]  a_v, a_r, b_v, b_r, c_v, c_r;
   logic [2:0]  d_v, d_r;
   logic [1:0]  a_sel, b_sel, c_sel, d_sel;
   logic [1:0]  a_src, b_src, c_src, d_src;
   logic [15:0] a_od, b_od, c_od, d_od;
   logic        a_ov, b_ov, c_ov, d_ov;
   logic        a_or, b_or, c_or, d_or;
   logic        a_busy, b_busy, c_busy, d_busy;

   stream_mux_nto1 #(.WIDTH(16), .N(4), .MODE(0), .BURST(1)) u_a (
      .clk(clk), .rst(rst), .in_data(a_d), .in_valid(a_v),
      .in_ready(a_r), .sel(a_sel), .out_data(a_od), .out_valid(a_ov),
      .out_ready(a_or), .out_src(a_src), .busy(a_busy));

   stream_mux_nto1 #(.WIDTH(16), .N(4), .MODE(1), .BURST(2)) u_b (
      .clk(clk), .rst(rst), .in_data(b_d), .in_valid(b_v),
      .in_ready(b_r), .sel(b_sel), .out_data(b_od), .out_valid(b_ov),
      .out_ready(b_or), .out_src(b_src), .busy(b_busy));

   stream_mux_nto1 #(.WIDTH(16), .N(4), .MODE(0), .BURST(4)) u_c (
      .clk(clk), .rst(rst), .in_data(c_d), .in_valid(c_v),
      .in_ready(c_r), .sel(c_sel), .out_data(c_od), .out_valid(c_ov),
      .out_ready(c_or), .out_src(c_src), .busy(c_busy));

   stream_mux_nto1 #(.WIDTH(16), .N(3), .MODE(0), .BURST(1)) u_d (
      .clk(clk), .rst(rst), .in_data(d_d), .in_valid(d_v),
      .in_ready(d_r), .sel(d_sel), .out_data(d_od), .out_valid(d_ov),
      .out_ready(d_or), .out_src(d_src), .busy(d_busy));

   function automatic logic [31:0] pk(input logic [1:0] s,
                                      input logic [15:0] d);
      return {14'b0, s, d};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic mon(input int id, input logic v, input logic r,
                      input logic [1:0] s, input logic [15:0] d);
      logic [31:0] e;
      if (v && r) begin
         if (sbq[id].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon%0d_extra actual=%h required=none",
                     id, pk(s, d));
         end else begin
            e = sbq[id].pop_front();
            chk($sformatf("mon%0d_beat", id), pk(s, d), e);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_ov, a_or, a_src, a_od);
      mon(1, b_ov, b_or, b_src, b_od);
      mon(2, c_ov, c_or, c_src, c_od);
      mon(3, d_ov, d_or, d_src, d_od);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_d = '0; b_d = '0; c_d = '0; d_d = '0;
      a_v = '0; b_v = '0; c_v = '0; d_v = '0;
      a_sel = '0; b_sel = '0; c_sel = '0; d_sel = '0;
      a_or = 1'b0; b_or = 1'b0; c_or = 1'b0; d_or = 1'b0;
      #1;
      chk("rst_ov", a_ov, 0);
      chk("rst_od", a_od, 0);
      chk("rst_src", a_src, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_rdy", a_r, 0);
      step();
      step();
      rst = 1'b0;

      // external select, single beat
      a_sel = 2'd2;
      a_d[47:32] = 16'hA5A5;
      a_v = 4'b0100;
      a_or = 1'b1;
      sbq[0].push_back(pk(2'd2, 16'hA5A5));
      #1;
      chk("a_arb_rdy", a_r, 4'b0000);
      step();
      chk("a_grant_rdy", a_r, 4'b0100);
      chk("a_grant_busy", a_busy, 1);
      chk("a_grant_ov", a_ov, 0);
      step();
      chk("a_beat_ov", a_ov, 1);
      chk("a_beat_od", a_od, 16'hA5A5);
      chk("a_beat_src", a_src, 2);
      chk("a_beat_busy", a_busy, 0);
      a_v = 4'b0000;
      step();
      chk("a_drain_ov", a_ov, 0);

      // backpressure
      a_sel = 2'd0;
      a_d[15:0] = 16'h1111;
      a_v = 4'b0001;
      a_or = 1'b0;
      sbq[0].push_back(pk(2'd0, 16'h1111));
      step();
      chk("bp_rdy0", a_r, 4'b0001);
      step();
      a_d[15:0] = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_ov", a_ov, 1);
         chk("bp_hold_od", a_od, 16'h1111);
         chk("bp_hold_rdy", a_r, 4'b0000);
         step();
      end
      a_or = 1'b1;
      #1;
      chk("bp_release_rdy", a_r, 4'b0001);
      sbq[0].push_back(pk(2'd0, 16'h2222));
      step();
      chk("bp_reload_ov", a_ov, 1);
      chk("bp_reload_od", a_od, 16'h2222);
      a_v = 4'b0000;
      step();
      chk("bp_end_ov", a_ov, 0);

      // round-robin, BURST=2
      b_d = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
      b_v = 4'b1111;
      b_or = 1'b1;
      begin
         logic [1:0] seq [9];
         seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
         for (int i = 0; i < 9; i++)
            sbq[1].push_back(pk(seq[i], {14'h2C00, seq[i]}));
      end
      for (int k = 1; k <= 14; k++) begin
         step();
         chk($sformatf("rr_ov_c%0d", k), b_ov, 32'((k % 3) != 1));
         chk($sformatf("rr_busy_c%0d", k), b_busy, 32'((k % 3) != 0));
      end
      b_v = 4'b0000;
      step();
      chk("rr_end_ov", b_ov, 0);
      chk("rr_end_busy", b_busy, 1);

      // burst lock, BURST=4
      c_sel = 2'd1;
      c_v = 4'b1010;
      c_d[31:16] = 16'hC101;
      c_d[63:48] = 16'hC3FF;
      c_or = 1'b1;
      for (int i = 1; i <= 4; i++)
         sbq[2].push_back(pk(2'd1, 16'hC100 + 16'(i)));
      step();
      chk("bl_grant_rdy", c_r, 4'b0010);
      step();
      c_d[31:16] = 16'hC102;
      step();
      c_sel = 2'd3;
      c_v = 4'b1000;
      #1;
      chk("bl_hold_rdy", c_r, 4'b0010);
      chk("bl_hold_busy", c_busy, 1);
      step();
      chk("bl_gap_ov", c_ov, 0);
      step();
      c_v = 4'b1010;
      c_d[31:16] = 16'hC103;
      step();
      c_d[31:16] = 16'hC104;
      step();
      chk("bl_last_busy", c_busy, 0);
      chk("bl_last_src", c_src, 1);
      chk("bl_last_od", c_od, 16'hC104);
      sbq[2].push_back(pk(2'd3, 16'hC3FF));
      step();
      chk("bl_ch3_rdy", c_r, 4'b1000);
      step();
      chk("bl_ch3_od", c_od, 16'hC3FF);
      chk("bl_ch3_src", c_src, 3);
      c_or = 1'b0;

      // asynchronous reset mid-burst with a pending beat
      #3;
      rst = 1'b1;
      #1;
      chk("mrst_ov", c_ov, 0);
      chk("mrst_od", c_od, 0);
      chk("mrst_src", c_src, 0);
      chk("mrst_busy", c_busy, 0);
      chk("mrst_rdy", c_r, 0);
      sbq[2].delete();
      step();
      rst = 1'b0;
      c_sel = 2'd2;
      c_v = 4'b0100;
      c_d[47:32] = 16'hC2AA;
      c_or = 1'b1;
      sbq[2].push_back(pk(2'd2, 16'hC2AA));
      #1;
      chk("prst_arb_rdy", c_r, 4'b0000);
      chk("prst_arb_busy", c_busy, 0);
      step();
      chk("prst_grant_rdy", c_r, 4'b0100);
      step();
      chk("prst_ov", c_ov, 1);
      chk("prst_od", c_od, 16'hC2AA);
      chk("prst_src", c_src, 2);
      c_v = 4'b0000;
      step();

      // out-of-range select on N=3
      d_sel = 2'd3;
      d_v = 3'b111;
      d_d = {16'hD002, 16'hD001, 16'hD000};
      d_or = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bad_sel_busy", d_busy, 0);
         chk("bad_sel_rdy", d_r, 0);
         chk("bad_sel_ov", d_ov, 0);
      end

      step();
      for (int id = 0; id < 4; id++)
         chk($sformatf("sb%0d_empty", id), sbq[id].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, a registered output and burst-locked channel grant. It generalises the fixed 2:1 16-bit data select to N channels of WIDTH bits. Selection is either externally driven or round-robin. It sits between parallel feature-map or weight sources and a single convolution datapath input, and holds the selected channel for a whole burst so that pixel groups are never interleaved.

## Interface
- WIDTH, 16: data width per channel, ≥1.
- N, 4: number of input channels, ≥1.
- MODE, 0: 0 = external select via `sel`; 1 = round-robin among valid channels.
- BURST, 1: beats transferred per grant before re-arbitration, ≥1.
- SEL_W, max(1, clog2(N)): select/source index width (derived, not overridden).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel data valid.
- in_ready  out  N  per-channel ready; at most one bit high.
- sel  in  SEL_W  channel select, MODE 0 only; sampled in ARB state.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts beat.
- out_src  out  SEL_W  channel index of the beat in out_data.
- busy  out  1  high while in XFER state.

## Operation
- State machine has 2 states: ARB and XFER. Registers: grant [SEL_W], beat counter [clog2(BURST)+1], rr pointer [SEL_W], output register.
- ARB, MODE 0: if sel < N and in_valid[sel], then grant <= sel, counter <= 0, go to XFER. Otherwise stay in ARB. If sel ≥ N, no grant is made and the block stays in ARB indefinitely.
- ARB, MODE 1: grant <= first i with in_valid[i], searching from rr+1 upward modulo N. If no input is valid, stay in ARB.
- While in ARB, all in_ready bits are 0.
- XFER: in_ready[grant] = !out_valid || out_ready (combinational). All other in_ready bits are 0.
- A beat is accepted when in_valid[grant] && in_ready[grant]. On acceptance: out_data <= channel data, out_src <= grant, out_valid <= 1, counter increments.
- If counter == BURST-1 when a beat is accepted: go to ARB and set rr <= grant.
- Output register: if out_valid && out_ready and no beat is accepted that cycle, out_valid <= 0. While out_valid && !out_ready, out_data and out_src hold stable.
- If the granted channel drops in_valid mid-burst, the block waits in XFER with the grant held. Changes on sel and valid bits on other channels are ignored until the burst completes.
- N=1: grant is always 0. MODE 1 behaves the same as MODE 0 with sel=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, busy=0, in_ready=0, state=ARB, grant=0, counter=0, rr=N-1. With rr=N-1, the first round-robin search starts at channel 0.
- Arbitration takes 1 cycle: valid is seen in ARB at cycle t, in_ready is high at t+1, and the first beat is accepted at t+1 if valid holds.
- Data latency is 1 cycle from acceptance to out_valid.
- Throughput within a burst is 1 beat per cycle with out_ready held high.
- Per-grant overhead is 1 ARB cycle. Steady state is BURST beats per BURST+1 cycles.
- When a beat is accepted and the output drains in the same cycle, the register is loaded with the new beat and out_valid stays 1.
- Reset asserted mid-burst clears all state immediately and asynchronously. Partial bursts and the pending output beat are discarded. Operation restarts in ARB on the first clk edge after rst deasserts.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.

## Test plan
- Reset: assert rst mid-burst with out_valid=1 → all outputs 0 immediately. After release, the first grant comes from ARB.
- MODE 0, N=4, WIDTH=16, BURST=1, sel=2, in_data ch2=16'hA5A5 valid → in_ready=4'b0100 one cycle later, then out_data=16'hA5A5, out_src=2 on the following cycle.
- MODE 1, N=4, BURST=2, all channels valid continuously, out_ready=1 → out_src sequence 0,0,1,1,2,2,3,3,0. Each pair is followed by a 1-cycle bubble.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 → out_data is stable and in_ready is all 0. On out_ready=1, the next beat loads in the same cycle and out_valid stays 1.
- Burst lock: MODE 0, BURST=4. Change sel from 1 to 3 after beat 2, and drop in_valid[1] for 2 cycles → remaining beats still come from ch1 with out_src=1. ch3 is granted only after beat 4.
- Invalid select: MODE 0, N=3, sel=3, all channels valid → busy stays 0 and in_ready stays 0 for 10 cycles.
